// File: rtl/nmx_wb_cmd_queue.sv
// Wishbone bridge from the management bus to the Neuromorphic_X1_wb macro.
// Writes are posted into a FIFO and replayed in order; reads wait for the FIFO to drain.
//
// state | meaning
// IDLE  | no macro cycle open; picks FIFO head first, then a pending read
// WR    | replaying FIFO head to the macro, waiting for ack or timeout
// RD    | upstream read forwarded to the macro, waiting for ack or timeout
// RDRSP | upstream ack pulse carrying the captured read data
module nmx_wb_cmd_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] STAT_ADDR = 32'h3000_FFFC,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        m_wbs_cyc_o,
    output logic        m_wbs_stb_o,
    output logic        m_wbs_we_o,
    output logic [3:0]  m_wbs_sel_o,
    output logic [31:0] m_wbs_adr_o,
    output logic [31:0] m_wbs_dat_o,
    input  logic [31:0] m_wbs_dat_i,
    input  logic        m_wbs_ack_i,
    output logic        err_irq_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WR, RD, RDRSP} state_t;

    state_t           state;
    logic [31:0]      fifo_adr [DEPTH];
    logic [31:0]      fifo_dat [DEPTH];
    logic [3:0]       fifo_sel [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             err;
    logic [15:0]      tmo_cnt;

    logic        req;
    logic        is_stat;
    logic        stat_acc;
    logic        push;
    logic        pop;
    logic        rd_pend;
    logic        in_cycle;
    logic        tmo_hit;
    logic        err_clr;
    logic [31:0] stat_word;

    // The ~wbs_ack_o term keeps a strobe held through the ack cycle from being seen twice.
    assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign is_stat  = (wbs_adr_i == STAT_ADDR);
    assign stat_acc = req & is_stat;
    assign push     = req & ~is_stat & wbs_we_i & (count != FULL_CNT);
    assign rd_pend  = req & ~is_stat & ~wbs_we_i;
    assign in_cycle = (state == WR) || (state == RD);
    assign tmo_hit  = in_cycle & ~m_wbs_ack_i & (tmo_cnt == TMO_LAST);
    assign pop      = (state == WR) & (m_wbs_ack_i | tmo_hit);
    assign err_clr  = stat_acc & wbs_we_i & wbs_sel_i[1] & wbs_dat_i[8];
    assign err_irq_o = err;

    always_comb begin
        stat_word             = '0;
        stat_word[CNT_W-1:0]  = count;
        stat_word[8]          = err;
        stat_word[9]          = (state != IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_adr[wr_ptr] <= wbs_adr_i;
            fifo_dat[wr_ptr] <= wbs_dat_i;
            fifo_sel[wr_ptr] <= wbs_sel_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err         <= 1'b0;
            tmo_cnt     <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            m_wbs_cyc_o <= 1'b0;
            m_wbs_stb_o <= 1'b0;
            m_wbs_we_o  <= 1'b0;
            m_wbs_sel_o <= '0;
            m_wbs_adr_o <= '0;
            m_wbs_dat_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // A timeout in the same cycle as a clear request leaves the flag set.
            if (tmo_hit)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;

            wbs_ack_o <= push | stat_acc;
            if (stat_acc && !wbs_we_i) wbs_dat_o <= stat_word;

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state       <= WR;
                        m_wbs_cyc_o <= 1'b1;
                        m_wbs_stb_o <= 1'b1;
                        m_wbs_we_o  <= 1'b1;
                        m_wbs_adr_o <= fifo_adr[rd_ptr];
                        m_wbs_dat_o <= fifo_dat[rd_ptr];
                        m_wbs_sel_o <= fifo_sel[rd_ptr];
                        tmo_cnt     <= '0;
                    end else if (rd_pend) begin
                        state       <= RD;
                        m_wbs_cyc_o <= 1'b1;
                        m_wbs_stb_o <= 1'b1;
                        m_wbs_we_o  <= 1'b0;
                        m_wbs_adr_o <= wbs_adr_i;
                        m_wbs_dat_o <= '0;
                        m_wbs_sel_o <= wbs_sel_i;
                        tmo_cnt     <= '0;
                    end
                end
                WR: begin
                    if (m_wbs_ack_i || tmo_hit) begin
                        state       <= IDLE;
                        m_wbs_cyc_o <= 1'b0;
                        m_wbs_stb_o <= 1'b0;
                        m_wbs_we_o  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                RD: begin
                    if (m_wbs_ack_i || tmo_hit) begin
                        state       <= RDRSP;
                        m_wbs_cyc_o <= 1'b0;
                        m_wbs_stb_o <= 1'b0;
                        wbs_ack_o   <= 1'b1;
                        wbs_dat_o   <= m_wbs_ack_i ? m_wbs_dat_i : ERR_DATA;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                RDRSP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
